cam_cfg_sched: RTL and testbench
================================

// Module: cam_cfg_sched
// PURPOSE
//  Schedules every OV7725 register write onto the single camera SCCB master, which it shares between two requesters.
//  - Requester 1: the power-up init table, from an internal ROM.
//  - Requester 2: runtime writes from the K230 (i2c_slave reg_wr/reg_addr/reg_data), buffered in a FIFO.
//  Runtime writes are applied only in vertical blanking, so a frame is never reconfigured mid-frame.
//  Sits between i2c_slave and the SCCB master; init_done gates cmos_data_top/dvp_tx.
// PARAMETERS
//  FIFO_DEPTH  8      host write FIFO entries (power of 2, >=2)
//  INIT_LEN    64     init ROM entries, indices 0..INIT_LEN-1
//  PWR_DLY     50000  clk_50m cycles of wait after reset/soft-reset (1 ms)
//  MAX_RETRY   3      re-issues after a NACK before the entry is abandoned
//  VSYNC_GATE  1      1: runtime writes issue only while vsync_s=1; 0: issue at any time
// PORTS
//  clk_50m     in   1   system clock, 50 MHz
//  rst         in   1   synchronous, active-high reset
//  host_wr     in   1   one-cycle write strobe (i2c_slave reg_wr)
//  host_addr   in   8   camera register address
//  host_data   in   8   camera register data
//  host_full   out  1   FIFO full
//  vsync_s     in   1   camera vsync, already synchronised to clk_50m; 1 = blanking
//  cmd_valid   out  1   SCCB command request
//  cmd_ready   in   1   SCCB master accepts the command
//  cmd_addr    out  8   register address of the command
//  cmd_data    out  8   register data of the command
//  rsp_valid   in   1   one-cycle pulse: transaction finished
//  rsp_nack    in   1   qualified by rsp_valid: slave NACKed
//  init_done   out  1   init table fully walked
//  busy        out  1   state is not RUN_IDLE
//  err         out  1   sticky: an entry was abandoned after retries
//  err_addr    out  8   address of the most recently abandoned entry
//  drop_cnt    out  8   host writes lost to a full FIFO; saturates at 255
// BEHAVIOUR
//  Reset values: all outputs 0, FIFO empty, state PWR_WAIT, delay counter 0.
//  States: PWR_WAIT -> INIT_ISSUE -> INIT_WAIT -> RUN_IDLE -> RUN_ISSUE -> RUN_WAIT.
//  PWR_WAIT
//   - counts PWR_DLY cycles, then goes to INIT_ISSUE with idx=0 and retry=0.
//  *_ISSUE
//   - cmd_valid=1 and cmd_addr/cmd_data are registered; they stay stable until cmd_ready.
//   - when cmd_valid&cmd_ready: cmd_valid drops next cycle and the state moves to *_WAIT.
//  *_WAIT, on rsp_valid:
//   - ack: retry=0; advance to the next entry.
//   - nack with retry<MAX_RETRY: retry++; re-issue the same entry.
//   - nack with retry=MAX_RETRY: err<=1, err_addr<=entry addr; advance as on ack.
//  Init advance:
//   - idx++; after the entry at idx=INIT_LEN-1, set init_done<=1 and go to RUN_IDLE.
//  RUN_IDLE
//   - when FIFO non-empty and (vsync_s | ~VSYNC_GATE): pop the FIFO head into the cmd registers, go to RUN_ISSUE.
//   - a transaction already issued completes even if vsync_s falls.
//  Runtime advance: back to RUN_IDLE.
//  Soft reset:
//   - trigger: an acked runtime write with addr 8'h12 (COM7) and data[7]=1.
//   - action: init_done<=0, go to PWR_WAIT, replay the whole init table.
//   - the FIFO is preserved across the soft reset.
//  FIFO
//   - pushes are accepted in every state, including during init.
//   - a push while full is dropped and increments drop_cnt, unless a pop occurs in the same cycle (then accepted).
//   - a push and a pop in the same cycle when empty: the push is stored; no bypass.
//  Priority: the init table is exclusive; FIFO entries are never issued while init_done=0.
//  rst at any time, including mid-transaction: immediate return to reset values. The SCCB master is reset by the same rst.
//  Latency: idle with FIFO empty, vsync_s=1, cmd_ready=1 -> host_wr at cycle N gives cmd_valid=1 at N+2.
// STRUCTURE
//  Package cam_cfg_pkg:
//   - state enum
//   - COM7_ADDR=8'h12, SOFT_RST_BIT=7
//   - cfg_entry_t {addr[7:0], data[7:0]}
//  Sub-module cam_init_rom: combinational idx -> cfg_entry_t, INIT_LEN entries.
//  The FIFO is inline (pointers plus a count register). No other sub-modules.
// TESTING
//  1 Reset release, SCCB model always acks -> exactly INIT_LEN commands in ROM order, the first after >=PWR_DLY cycles; then init_done=1, busy=0.
//  2 Model NACKs entry 5 four times -> that entry is issued 4 times; err=1; err_addr=ROM[5].addr; entry 6 follows; init_done still set.
//  3 With vsync_s=0, host writes (0x11,0x01) then (0x0C,0x40) -> no cmd; vsync_s=1 -> both issued in order, one transaction each.
//  4 9 back-to-back host_wr with the FIFO blocked (vsync_s=0) -> host_full=1 after 8, drop_cnt=1, first 8 entries intact.
//  5 Host write (0x12,0x80) acked -> init_done=0, PWR_WAIT, full ROM replay; a FIFO entry queued during the replay issues after it.
//  6 rst asserted while cmd_valid=1 and waiting on cmd_ready -> next cycle all outputs 0, state PWR_WAIT.

Source files
------------

// File: rtl/cam_cfg_pkg.sv
// Shared types and constants for the OV7725 configuration scheduler.
// INIT_TABLE holds the power-up register sequence as {addr, data} pairs.
package cam_cfg_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT_ISSUE,
    INIT_WAIT,
    RUN_IDLE,
    RUN_ISSUE,
    RUN_WAIT
  } sched_state_e;

  localparam logic [7:0] COM7_ADDR    = 8'h12;
  localparam int         SOFT_RST_BIT = 7;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } cfg_entry_t;

  localparam int ROM_SIZE = 64;

  localparam logic [15:0] INIT_TABLE [ROM_SIZE] = '{
    16'h1280, 16'h3D03, 16'h1722, 16'h18A4, 16'h1907, 16'h1AF0, 16'h3200, 16'h29A0,
    16'h2CF0, 16'h2A00, 16'h1101, 16'h427F, 16'h4D09, 16'h63E0, 16'h64FF, 16'h6520,
    16'h6600, 16'h6748, 16'h13F0, 16'h0D41, 16'h0FC5, 16'h1411, 16'h227F, 16'h2303,
    16'h2440, 16'h2530, 16'h26A1, 16'h2B00, 16'h6BAA, 16'h13FF, 16'h9005, 16'h9101,
    16'h9203, 16'h9300, 16'h94B0, 16'h959D, 16'h9613, 16'h9716, 16'h987B, 16'h9991,
    16'h9A1E, 16'h9B08, 16'h9C20, 16'h9E81, 16'hA604, 16'h7E0C, 16'h7F16, 16'h802A,
    16'h814E, 16'h8261, 16'h836F, 16'h847B, 16'h8586, 16'h868E, 16'h8797, 16'h88A4,
    16'h89AF, 16'h8AC5, 16'h8BD7, 16'h8CE8, 16'h8D20, 16'h0E65, 16'h0C10, 16'h0900
  };

endpackage

// File: rtl/cam_init_rom.sv
// Combinational init ROM: index -> {addr, data}. Indices past the table read as zero.
module cam_init_rom
  import cam_cfg_pkg::*;
#(
  parameter int INIT_LEN = 64,
  parameter int IDX_W    = 6
) (
  input  logic [IDX_W-1:0] idx_i,
  output cfg_entry_t       entry_o
);

  always_comb begin
    entry_o = '0;
    if ((int'(idx_i) < INIT_LEN) && (int'(idx_i) < ROM_SIZE)) begin
      entry_o = cfg_entry_t'(INIT_TABLE[idx_i]);
    end
  end

endmodule

// File: rtl/cam_cfg_sched.sv
// Arbitrates the camera SCCB master between the init ROM walk and buffered host writes.
// Host writes are only issued after init completes, and (optionally) only in vertical blanking.
module cam_cfg_sched
  import cam_cfg_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int INIT_LEN   = 64,
  parameter int PWR_DLY    = 50000,
  parameter int MAX_RETRY  = 3,
  parameter bit VSYNC_GATE = 1'b1
) (
  input  logic       clk_50m_i,
  input  logic       rst_i,
  input  logic       host_wr_i,
  input  logic [7:0] host_addr_i,
  input  logic [7:0] host_data_i,
  output logic       host_full_o,
  input  logic       vsync_s_i,
  output logic       cmd_valid_o,
  input  logic       cmd_ready_i,
  output logic [7:0] cmd_addr_o,
  output logic [7:0] cmd_data_o,
  input  logic       rsp_valid_i,
  input  logic       rsp_nack_i,
  output logic       init_done_o,
  output logic       busy_o,
  output logic       err_o,
  output logic [7:0] err_addr_o,
  output logic [7:0] drop_cnt_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int IDX_W = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;
  localparam int DLY_W = (PWR_DLY > 1) ? $clog2(PWR_DLY) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [DLY_W-1:0] DLY_LAST  = DLY_W'(PWR_DLY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(INIT_LEN - 1);
  localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRY);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  sched_state_e     state_q, state_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [IDX_W-1:0] idx_q, idx_d, rom_idx;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [7:0]       cmd_addr_q, cmd_addr_d, cmd_data_q, cmd_data_d;
  logic             init_done_q, init_done_d;
  logic             err_q, err_d;
  logic [7:0]       err_addr_q, err_addr_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic             busy_q;
  cfg_entry_t       rom_entry;

  cfg_entry_t       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             fifo_full, fifo_empty, push, pop, drop, soft_rst_hit;

  assign fifo_full    = (count_q == FIFO_FULL);
  assign fifo_empty   = (count_q == '0);
  assign push         = host_wr_i && (!fifo_full || pop);
  assign drop         = host_wr_i && fifo_full && !pop;
  assign drop_cnt_d   = (drop && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  assign soft_rst_hit = (cmd_addr_q == COM7_ADDR) && cmd_data_q[SOFT_RST_BIT];

  // The ROM is addressed with the entry about to be loaded: 0 on leaving PWR_WAIT, else idx+1.
  assign rom_idx = (state_q == PWR_WAIT) ? '0 : idx_q + 1'b1;

  cam_init_rom #(
    .INIT_LEN(INIT_LEN),
    .IDX_W   (IDX_W)
  ) u_init_rom (
    .idx_i  (rom_idx),
    .entry_o(rom_entry)
  );

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    dly_d       = dly_q;
    idx_d       = idx_q;
    retry_d     = retry_q;
    cmd_valid_d = cmd_valid_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_data_d  = cmd_data_q;
    init_done_d = init_done_q;
    err_d       = err_q;
    err_addr_d  = err_addr_q;
    pop         = 1'b0;
    case (state_q)
      PWR_WAIT: begin
        if (dly_q == DLY_LAST) begin
          dly_d       = '0;
          idx_d       = '0;
          retry_d     = '0;
          cmd_valid_d = 1'b1;
          cmd_addr_d  = rom_entry.addr;
          cmd_data_d  = rom_entry.data;
          state_d     = INIT_ISSUE;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      INIT_ISSUE, RUN_ISSUE: begin
        if (cmd_ready_i) begin
          cmd_valid_d = 1'b0;
          state_d     = (state_q == INIT_ISSUE) ? INIT_WAIT : RUN_WAIT;
        end
      end
      INIT_WAIT, RUN_WAIT: begin
        if (rsp_valid_i) begin
          if (rsp_nack_i && (retry_q < RTY_MAX)) begin
            retry_d     = retry_q + 1'b1;
            cmd_valid_d = 1'b1;
            state_d     = (state_q == INIT_WAIT) ? INIT_ISSUE : RUN_ISSUE;
          end else begin
            retry_d = '0;
            if (rsp_nack_i) begin
              err_d      = 1'b1;
              err_addr_d = cmd_addr_q;
            end
            if (state_q == INIT_WAIT) begin
              if (idx_q == IDX_LAST) begin
                init_done_d = 1'b1;
                state_d     = RUN_IDLE;
              end else begin
                idx_d       = idx_q + 1'b1;
                cmd_valid_d = 1'b1;
                cmd_addr_d  = rom_entry.addr;
                cmd_data_d  = rom_entry.data;
                state_d     = INIT_ISSUE;
              end
            end else if (!rsp_nack_i && soft_rst_hit) begin
              // Camera was just soft-reset: its registers are back at defaults, replay init.
              init_done_d = 1'b0;
              dly_d       = '0;
              state_d     = PWR_WAIT;
            end else begin
              state_d = RUN_IDLE;
            end
          end
        end
      end
      RUN_IDLE: begin
        if (init_done_q && !fifo_empty && (vsync_s_i || !VSYNC_GATE)) begin
          pop         = 1'b1;
          cmd_valid_d = 1'b1;
          cmd_addr_d  = fifo_mem[rd_ptr_q].addr;
          cmd_data_d  = fifo_mem[rd_ptr_q].data;
          state_d     = RUN_ISSUE;
        end
      end
      default: state_d = PWR_WAIT;
    endcase
  end

  // busy is registered from the next state so it reads 0 in the cycle right after reset.
  always_ff @(posedge clk_50m_i) begin
    if (rst_i) begin
      state_q     <= PWR_WAIT;
      dly_q       <= '0;
      idx_q       <= '0;
      retry_q     <= '0;
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      err_addr_q  <= '0;
      drop_cnt_q  <= '0;
      busy_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      dly_q       <= dly_d;
      idx_q       <= idx_d;
      retry_q     <= retry_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_data_q  <= cmd_data_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
      drop_cnt_q  <= drop_cnt_d;
      busy_q      <= (state_d != RUN_IDLE);
      count_q     <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_50m_i) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= '{addr: host_addr_i, data: host_data_i};
    end
  end

  assign host_full_o = fifo_full;
  assign cmd_valid_o = cmd_valid_q;
  assign cmd_addr_o  = cmd_addr_q;
  assign cmd_data_o  = cmd_data_q;
  assign init_done_o = init_done_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;
  assign err_addr_o  = err_addr_q;
  assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_cam_cfg_sched.sv
// Directed bench for cam_cfg_sched with a small SCCB master model that records accepted commands.
module tb_cam_cfg_sched;
  import cam_cfg_pkg::*;

  localparam int PWR_DLY  = 20;
  localparam int INIT_LEN = 64;

  localparam logic [15:0] romModel [64] = '{
    16'h1280, 16'h3D03, 16'h1722, 16'h18A4, 16'h1907, 16'h1AF0, 16'h3200, 16'h29A0,
    16'h2CF0, 16'h2A00, 16'h1101, 16'h427F, 16'h4D09, 16'h63E0, 16'h64FF, 16'h6520,
    16'h6600, 16'h6748, 16'h13F0, 16'h0D41, 16'h0FC5, 16'h1411, 16'h227F, 16'h2303,
    16'h2440, 16'h2530, 16'h26A1, 16'h2B00, 16'h6BAA, 16'h13FF, 16'h9005, 16'h9101,
    16'h9203, 16'h9300, 16'h94B0, 16'h959D, 16'h9613, 16'h9716, 16'h987B, 16'h9991,
    16'h9A1E, 16'h9B08, 16'h9C20, 16'h9E81, 16'hA604, 16'h7E0C, 16'h7F16, 16'h802A,
    16'h814E, 16'h8261, 16'h836F, 16'h847B, 16'h8586, 16'h868E, 16'h8797, 16'h88A4,
    16'h89AF, 16'h8AC5, 16'h8BD7, 16'h8CE8, 16'h8D20, 16'h0E65, 16'h0C10, 16'h0900
  };

  logic       clk, rst, hostWr, hostFull, vsyncS, cmdValid, cmdReady;
  logic [7:0] hostAddr, hostData, cmdAddr, cmdData, errAddr, dropCnt;
  logic       rspValid, rspNack, initDone, busy, err;

  int          checkCount = 0;
  int          passCount  = 0;
  logic [15:0] issued [$];
  logic [15:0] expected [$];
  logic [7:0]  nackAddr   = 8'h00;
  int          nackBudget = 0;

  cam_cfg_sched #(
    .FIFO_DEPTH(8),
    .INIT_LEN  (INIT_LEN),
    .PWR_DLY   (PWR_DLY),
    .MAX_RETRY (3),
    .VSYNC_GATE(1'b1)
  ) dut (
    .clk_50m_i  (clk),
    .rst_i      (rst),
    .host_wr_i  (hostWr),
    .host_addr_i(hostAddr),
    .host_data_i(hostData),
    .host_full_o(hostFull),
    .vsync_s_i  (vsyncS),
    .cmd_valid_o(cmdValid),
    .cmd_ready_i(cmdReady),
    .cmd_addr_o (cmdAddr),
    .cmd_data_o (cmdData),
    .rsp_valid_i(rspValid),
    .rsp_nack_i (rspNack),
    .init_done_o(initDone),
    .busy_o     (busy),
    .err_o      (err),
    .err_addr_o (errAddr),
    .drop_cnt_o (dropCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SCCB model: logs each accepted command and answers it three cycles later.
  initial begin
    int pend;
    int nacksGiven;
    logic nackNext;
    pend       = 0;
    nacksGiven = 0;
    nackNext   = 1'b0;
    rspValid   = 1'b0;
    rspNack    = 1'b0;
    forever begin
      @(negedge clk);
      rspValid = 1'b0;
      rspNack  = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          rspValid = 1'b1;
          rspNack  = nackNext;
        end
      end
      if (!rst && cmdValid && cmdReady) begin
        issued.push_back({cmdAddr, cmdData});
        nackNext = (cmdAddr == nackAddr) && (nacksGiven < nackBudget);
        if (nackNext) nacksGiven++;
        pend = 3;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] want);
    checkCount++;
    assert (observed === want) passCount++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, want);
  endtask

  task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] data);
    hostAddr = addr;
    hostData = data;
    hostWr   = 1'b1;
    @(negedge clk);
    hostWr   = 1'b0;
  endtask

  task automatic checkIssued(input string tag);
    logic [15:0] obs;
    checkOutput({tag, "_count"}, 32'(issued.size()), 32'(expected.size()));
    for (int i = 0; i < expected.size(); i++) begin
      obs = (i < issued.size()) ? issued[i] : 16'hxxxx;
      checkOutput($sformatf("%s_cmd%0d", tag, i), 32'(obs), 32'(expected[i]));
    end
  endtask

  initial begin
    int cyc;
    logic timedOut;
    rst = 1'b1; hostWr = 1'b0; hostAddr = '0; hostData = '0;
    vsyncS = 1'b0; cmdReady = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_cmd_valid", 32'(cmdValid), 0);
    checkOutput("rst_init_done", 32'(initDone), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_host_full", 32'(hostFull), 0);
    checkOutput("rst_drop_cnt", 32'(dropCnt), 0);
    checkOutput("rst_state", 32'(dut.state_q), 32'(PWR_WAIT));

    $display("[TB] power-up init walk");
    rst = 1'b0;
    cyc = 0;
    timedOut = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      cyc++;
      if (cmdValid) begin timedOut = 1'b0; break; end
    end
    checkOutput("t1_first_cmd_timeout", 32'(timedOut), 0);
    checkOutput("t1_pwr_delay_min", 32'(cyc >= PWR_DLY), 1);
    checkOutput("t1_pwr_delay_max", 32'(cyc <= PWR_DLY + 2), 1);
    checkOutput("t1_busy_during_init", 32'(busy), 1);
    timedOut = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (initDone && !busy) begin timedOut = 1'b0; break; end
    end
    checkOutput("t1_init_timeout", 32'(timedOut), 0);
    expected.delete();
    for (int i = 0; i < INIT_LEN; i++) expected.push_back(romModel[i]);
    checkIssued("t1");
    checkOutput("t1_err", 32'(err), 0);

    $display("[TB] runtime writes held outside blanking");
    issued.delete();
    applyStimulus(8'h11, 8'h01);
    applyStimulus(8'h0C, 8'h40);
    repeat (20) @(negedge clk);
    checkOutput("t3_no_cmd_in_frame", 32'(issued.size()), 0);
    checkOutput("t3_cmd_valid_low", 32'(cmdValid), 0);
    vsyncS = 1'b1;
    timedOut = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (issued.size() >= 2 && !busy) begin timedOut = 1'b0; break; end
    end
    checkOutput("t3_drain_timeout", 32'(timedOut), 0);
    expected.delete();
    expected.push_back(16'h1101);
    expected.push_back(16'h0C40);
    checkIssued("t3");

    $display("[TB] host write latency");
    issued.delete();
    applyStimulus(8'h11, 8'h02);
    checkOutput("lat_n1_cmd_valid", 32'(cmdValid), 0);
    @(negedge clk);
    checkOutput("lat_n2_cmd_valid", 32'(cmdValid), 1);
    checkOutput("lat_n2_cmd", 32'({cmdAddr, cmdData}), 32'h1102);
    repeat (10) @(negedge clk);
    checkOutput("lat_busy_after", 32'(busy), 0);

    $display("[TB] FIFO overflow");
    vsyncS = 1'b0;
    issued.delete();
    for (int i = 0; i < 8; i++) applyStimulus(8'(8'h20 + i), 8'(8'h30 + i));
    checkOutput("t4_full_after8", 32'(hostFull), 1);
    checkOutput("t4_drop_after8", 32'(dropCnt), 0);
    applyStimulus(8'h28, 8'h38);
    checkOutput("t4_full_after9", 32'(hostFull), 1);
    checkOutput("t4_drop_after9", 32'(dropCnt), 1);
    vsyncS = 1'b1;
    timedOut = 1'b1;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (issued.size() >= 8 && !busy) begin timedOut = 1'b0; break; end
    end
    checkOutput("t4_drain_timeout", 32'(timedOut), 0);
    expected.delete();
    for (int i = 0; i < 8; i++) expected.push_back({8'(8'h20 + i), 8'(8'h30 + i)});
    checkIssued("t4");
    checkOutput("t4_full_cleared", 32'(hostFull), 0);

    $display("[TB] soft reset replay with NACKs on entry 5");
    issued.delete();
    nackAddr   = romModel[5][15:8];
    nackBudget = 4;
    applyStimulus(COM7_ADDR, 8'h80);
    timedOut = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!initDone) begin timedOut = 1'b0; break; end
    end
    checkOutput("t5_soft_rst_timeout", 32'(timedOut), 0);
    checkOutput("t5_state_pwr_wait", 32'(dut.state_q), 32'(PWR_WAIT));
    checkOutput("t5_busy", 32'(busy), 1);
    applyStimulus(8'h55, 8'hAA);
    timedOut = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (issued.size() >= 69 && !busy) begin timedOut = 1'b0; break; end
    end
    checkOutput("t5_replay_timeout", 32'(timedOut), 0);
    expected.delete();
    expected.push_back(16'h1280);
    for (int i = 0; i < INIT_LEN; i++) begin
      expected.push_back(romModel[i]);
      if (i == 5) repeat (3) expected.push_back(romModel[i]);
    end
    expected.push_back(16'h55AA);
    checkIssued("t5");
    checkOutput("t5_err", 32'(err), 1);
    checkOutput("t5_err_addr", 32'(errAddr), 32'(romModel[5][15:8]));
    checkOutput("t5_init_done", 32'(initDone), 1);
    checkOutput("t5_drop_kept", 32'(dropCnt), 1);

    $display("[TB] reset while a command is stalled");
    cmdReady = 1'b0;
    applyStimulus(8'h33, 8'h44);
    timedOut = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (cmdValid) begin timedOut = 1'b0; break; end
      @(negedge clk);
    end
    checkOutput("t6_stall_timeout", 32'(timedOut), 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t6_cmd_valid", 32'(cmdValid), 0);
    checkOutput("t6_cmd", 32'({cmdAddr, cmdData}), 0);
    checkOutput("t6_init_done", 32'(initDone), 0);
    checkOutput("t6_busy", 32'(busy), 0);
    checkOutput("t6_err", 32'(err), 0);
    checkOutput("t6_err_addr", 32'(errAddr), 0);
    checkOutput("t6_drop_cnt", 32'(dropCnt), 0);
    checkOutput("t6_host_full", 32'(hostFull), 0);
    checkOutput("t6_state", 32'(dut.state_q), 32'(PWR_WAIT));
    rst = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
